inert_seq: RTL and testbench

Sequencer that owns the inertial sensor's SPI link and feeds the pitch integrator. After reset it waits for the sensor to power up, then issues four configuration writes. After that, it services each data-ready interrupt with four byte reads (pitch-rate low/high, AZ low/high). It presents a coherent {ptch_rt, AZ} pair with a single-cycle vld pulse. It sits between the SPI master and the inertial integrator.

---
 rtl/inert_seq_pkg.sv | 27 ++
 rtl/inert_int_sync.sv | 14 +
 rtl/inert_seq.sv | 111 +++++++++++
 tb/tb_inert_seq.sv | 132 +++++++++++++
 4 files changed

// File: rtl/inert_seq_pkg.sv
// inert_seq_pkg: sequencer states, sensor SPI command words and state helpers
package inert_seq_pkg;
  typedef enum logic [3:0] {
    INIT_WAIT, CFG0, CFG1, CFG2, CFG3, IDLE, RD_PL, RD_PH, RD_AL, RD_AH, PUBLISH
  } state_t;
  localparam logic [15:0] CFG0_CMD  = 16'h0D02;
  localparam logic [15:0] CFG1_CMD  = 16'h1053;
  localparam logic [15:0] CFG2_CMD  = 16'h1150;
  localparam logic [15:0] CFG3_CMD  = 16'h1460;
  localparam logic [15:0] RD_PL_CMD = 16'hA200;
  localparam logic [15:0] RD_PH_CMD = 16'hA300;
  localparam logic [15:0] RD_AL_CMD = 16'hAC00;
  localparam logic [15:0] RD_AH_CMD = 16'hAD00;
  function automatic logic [15:0] cmd_of(input state_t s);
    return s == CFG0  ? CFG0_CMD  :
           s == CFG1  ? CFG1_CMD  :
           s == CFG2  ? CFG2_CMD  :
           s == CFG3  ? CFG3_CMD  :
           s == RD_PL ? RD_PL_CMD :
           s == RD_PH ? RD_PH_CMD :
           s == RD_AL ? RD_AL_CMD :
           s == RD_AH ? RD_AH_CMD : 16'h0000;
  endfunction
  function automatic logic is_xact(input state_t s);
    return s != INIT_WAIT && s != IDLE && s != PUBLISH;
  endfunction
endpackage

// File: rtl/inert_int_sync.sv
// inert_int_sync: two-flop synchronizer plus edge flop giving a one-cycle int_rise
module inert_int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic int_async,
  output logic int_rise
);
  logic [2:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[1:0], int_async};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
  assign int_rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/inert_seq.sv
// inert_seq: inertial sensor SPI sequencer publishing coherent pitch-rate/AZ pairs
module inert_seq
  import inert_seq_pkg::*;
#(
  parameter int INIT_WAIT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld
);
  state_t state_q, state_d;
  logic [INIT_WAIT_BITS-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, pend_q, pend_d, wrt_q, wrt_d, vld_q, vld_d;
  logic [7:0] pl_q, pl_d, ph_q, ph_d, al_q, al_d;
  logic [15:0] cmd_q, cmd_d, ptch_q, ptch_d, az_q, az_d;
  logic int_rise, xact, fin;
  logic unused_hi;
  assign unused_hi = ^rd_data[15:8];
  inert_int_sync u_sync (.clk(clk), .rst_n(rst_n), .int_async(INT), .int_rise(int_rise));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pl_d    = pl_q;
    ph_d    = ph_q;
    al_d    = al_q;
    ptch_d  = ptch_q;
    az_d    = az_q;
    vld_d   = 1'b0;
    xact    = is_xact(state_q);
    fin     = xact & busy_q & done;
    case (state_q)
      INIT_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = CFG0;
      end
      CFG0: if (fin) state_d = CFG1;
      CFG1: if (fin) state_d = CFG2;
      CFG2: if (fin) state_d = CFG3;
      CFG3: if (fin) state_d = IDLE;
      IDLE: if (int_rise | pend_q) begin
        state_d = RD_PL;
        pend_d  = 1'b0;
      end
      RD_PL: if (fin) begin
        pl_d    = rd_data[7:0];
        state_d = RD_PH;
      end
      RD_PH: if (fin) begin
        ph_d    = rd_data[7:0];
        state_d = RD_AL;
      end
      RD_AL: if (fin) begin
        al_d    = rd_data[7:0];
        state_d = RD_AH;
      end
      RD_AH: if (fin) begin
        ptch_d  = {ph_q, pl_q};
        az_d    = {rd_data[7:0], al_q};
        vld_d   = 1'b1;
        state_d = PUBLISH;
      end
      PUBLISH: state_d = IDLE;
      default: state_d = INIT_WAIT;
    endcase
    if (int_rise && state_q inside {RD_PL, RD_PH, RD_AL, RD_AH, PUBLISH}) pend_d = 1'b1;
    wrt_d  = xact & ~busy_q;
    busy_d = wrt_d | (busy_q & ~fin);
    cmd_d  = wrt_d ? cmd_of(state_q) : cmd_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= INIT_WAIT;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      wrt_q   <= 1'b0;
      vld_q   <= 1'b0;
      pl_q    <= '0;
      ph_q    <= '0;
      al_q    <= '0;
      cmd_q   <= '0;
      ptch_q  <= '0;
      az_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      wrt_q   <= wrt_d;
      vld_q   <= vld_d;
      pl_q    <= pl_d;
      ph_q    <= ph_d;
      al_q    <= al_d;
      cmd_q   <= cmd_d;
      ptch_q  <= ptch_d;
      az_q    <= az_d;
    end
  assign wrt     = wrt_q;
  assign cmd     = cmd_q;
  assign ptch_rt = ptch_q;
  assign AZ      = az_q;
  assign vld     = vld_q;
endmodule

// File: tb/tb_inert_seq.sv
// tb_inert_seq: directed bench acting as SPI master/sensor around inert_seq
module tb_inert_seq;
  import inert_seq_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, INT = 1'b0, done = 1'b0;
  logic [15:0] rd_data = '0;
  logic wrt, vld;
  logic [15:0] cmd, ptch_rt, AZ;
  int checks = 0, errors = 0;
  int n;
  inert_seq #(.INIT_WAIT_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .ptch_rt(ptch_rt), .AZ(AZ), .vld(vld)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_wrt(input int lim, output int cnt);
    cnt = lim;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (wrt === 1'b1) begin
        cnt = i;
        break;
      end
    end
  endtask
  task automatic quiet(input string tag, input int cycles);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (wrt !== 1'b0 || vld !== 1'b0) hits++;
    end
    chk(tag, hits, 0);
  endtask
  task automatic serve(input logic [15:0] c, input logic [7:0] b, input int exp_n,
                       input bit p2, input bit exp_vld);
    int cnt;
    wait_wrt(40, cnt);
    chk($sformatf("lat_%h", c), cnt, exp_n);
    chk($sformatf("cmd_%h", c), cmd, c);
    @(negedge clk);
    chk($sformatf("wrt_pulse_%h", c), wrt, 0);
    chk($sformatf("cmd_hold_%h", c), cmd, c);
    for (int i = 0; i < (p2 ? 5 : 1); i++) begin
      INT = p2 && (i == 0 || i == 2);
      @(negedge clk);
    end
    INT = 1'b0;
    done = 1'b1;
    rd_data = {8'hA5, b};
    @(negedge clk);
    done = 1'b0;
    chk($sformatf("vld_%h", c), vld, exp_vld);
  endtask
  task automatic init(input bit stray);
    serve(CFG0_CMD, 8'h00, 17, 0, 0);
    INT = stray;
    serve(CFG1_CMD, 8'h00, 1, 0, 0);
    serve(CFG2_CMD, 8'h00, 1, 0, 0);
    serve(CFG3_CMD, 8'h00, 1, 0, 0);
  endtask
  task automatic rd_seq(input bit do_int, input int n0, input logic [7:0] pl, ph, al, ah,
                        input logic [15:0] op, oaz, input bit pulse_ph);
    if (do_int) begin
      INT = 1'b1;
      @(negedge clk);
      INT = 1'b0;
    end
    serve(RD_PL_CMD, pl, n0, 0, 0);
    chk("hold_p_pl", ptch_rt, op);
    chk("hold_a_pl", AZ, oaz);
    serve(RD_PH_CMD, ph, 1, pulse_ph, 0);
    serve(RD_AL_CMD, al, 1, 0, 0);
    chk("hold_p_al", ptch_rt, op);
    chk("hold_a_al", AZ, oaz);
    serve(RD_AH_CMD, ah, 1, 0, 1);
    chk("ptch_rt", ptch_rt, {ph, pl});
    chk("AZ", AZ, {ah, al});
    @(negedge clk);
    chk("vld_single", vld, 0);
  endtask
  initial begin
    #1;
    chk("rst_wrt", wrt, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_vld", vld, 0);
    chk("rst_ptch", ptch_rt, 0);
    chk("rst_az", AZ, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    init(1);
    quiet("idle_after_cfg", 6);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    quiet("stray_done", 8);
    rd_seq(1, 3, 8'h34, 8'h12, 8'h78, 8'hF6, 16'h0000, 16'h0000, 0);
    quiet("idle_after_rd1", 4);
    rd_seq(1, 3, 8'h01, 8'h00, 8'h02, 8'h00, 16'h1234, 16'hF678, 0);
    rd_seq(1, 3, 8'h11, 8'h22, 8'h33, 8'h44, 16'h0001, 16'h0002, 1);
    rd_seq(0, 2, 8'h55, 8'h66, 8'h77, 8'h88, 16'h2211, 16'h4433, 0);
    quiet("single_pending", 10);
    INT = 1'b1;
    @(negedge clk);
    INT = 1'b0;
    serve(RD_PL_CMD, 8'hAA, 3, 0, 0);
    serve(RD_PH_CMD, 8'hBB, 1, 0, 0);
    wait_wrt(40, n);
    chk("lat_al_rst", n, 1);
    chk("cmd_al_rst", cmd, RD_AL_CMD);
    rst_n = 1'b0;
    #1;
    chk("arst_wrt", wrt, 0);
    chk("arst_cmd", cmd, 0);
    chk("arst_ptch", ptch_rt, 0);
    chk("arst_az", AZ, 0);
    chk("arst_vld", vld, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    init(0);
    chk("reinit_ptch", ptch_rt, 0);
    chk("reinit_az", AZ, 0);
    quiet("reinit_idle", 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
